// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, direct-mapped one-word-per-line instruction cache,
// miss handling over the mem_ctrl transmit/inst_rdy handshake, and a registered decoder output.
module inst_fetch_unit #(
    parameter int          ICACHE_ENTRIES = 256,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        transmit_to_mem_ctrl,
    output logic [31:0] inst_addr_to_mem_ctrl,
    input  logic        inst_rdy_from_mem_ctrl,
    input  logic [31:0] inst_from_mem_ctrl,
    input  logic        stall_from_decoder,
    output logic        inst_valid_to_decoder,
    output logic [31:0] inst_to_decoder,
    output logic [31:0] pc_to_decoder,
    input  logic        flush_from_commit,
    input  logic [31:0] target_pc_from_commit
);

    localparam int IDX   = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic {LOOKUP, MISS} state_t;

    state_t              state, state_next;
    logic [31:0]         pc;
    logic [ICACHE_ENTRIES-1:0] line_valid;
    logic [TAG_W-1:0]    line_tag  [ICACHE_ENTRIES];
    logic [31:0]         line_data [ICACHE_ENTRIES];

    logic [IDX-1:0]      idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                hit;
    logic                out_free;
    logic                fill;

    assign idx      = pc[IDX+1:2];
    assign pc_tag   = pc[31:IDX+2];
    assign hit      = line_valid[idx] && (line_tag[idx] == pc_tag);
    assign out_free = !inst_valid_to_decoder || !stall_from_decoder;
    // A fill coinciding with a flush belongs to an abandoned fetch and is dropped.
    assign fill     = rdy_in && (state == MISS) && inst_rdy_from_mem_ctrl && !flush_from_commit;

    assign transmit_to_mem_ctrl  = (state == MISS) && !inst_rdy_from_mem_ctrl && !flush_from_commit;
    assign inst_addr_to_mem_ctrl = pc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= LOOKUP;
        else if (rdy_in)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush_from_commit)
            state_next = LOOKUP;
        else begin
            case (state)
                LOOKUP:  if (!hit) state_next = MISS;
                MISS:    if (inst_rdy_from_mem_ctrl) state_next = LOOKUP;
                default: state_next = LOOKUP;
            endcase
        end
    end

    // Output register drops valid whenever the decoder takes the word and nothing new is issued,
    // so a held instruction is never presented twice.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc                    <= RESET_PC;
            inst_valid_to_decoder <= 1'b0;
            inst_to_decoder       <= 32'h0;
            pc_to_decoder         <= 32'h0;
        end else if (rdy_in) begin
            if (flush_from_commit) begin
                pc                    <= target_pc_from_commit;
                inst_valid_to_decoder <= 1'b0;
            end else if (out_free) begin
                if (state == LOOKUP && hit) begin
                    inst_to_decoder       <= line_data[idx];
                    pc_to_decoder         <= pc;
                    inst_valid_to_decoder <= 1'b1;
                    pc                    <= pc + 32'd4;
                end else begin
                    inst_valid_to_decoder <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            line_valid <= '0;
        else if (fill)
            line_valid[idx] <= 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            line_tag[idx]  <= pc_tag;
            line_data[idx] <= inst_from_mem_ctrl;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit: miss/fill, hits, stall, flush, conflict, reset and freeze.
module tb_inst_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        transmit_to_mem_ctrl;
    logic [31:0] inst_addr_to_mem_ctrl;
    logic        inst_rdy_from_mem_ctrl;
    logic [31:0] inst_from_mem_ctrl;
    logic        stall_from_decoder;
    logic        inst_valid_to_decoder;
    logic [31:0] inst_to_decoder;
    logic [31:0] pc_to_decoder;
    logic        flush_from_commit;
    logic [31:0] target_pc_from_commit;

    int compared   = 0;
    int mismatched = 0;

    inst_fetch_unit #(.ICACHE_ENTRIES(256), .RESET_PC(32'h0)) dut (
        .clk_in                 (clk_in),
        .rst_n_in               (rst_n_in),
        .rdy_in                 (rdy_in),
        .transmit_to_mem_ctrl   (transmit_to_mem_ctrl),
        .inst_addr_to_mem_ctrl  (inst_addr_to_mem_ctrl),
        .inst_rdy_from_mem_ctrl (inst_rdy_from_mem_ctrl),
        .inst_from_mem_ctrl     (inst_from_mem_ctrl),
        .stall_from_decoder     (stall_from_decoder),
        .inst_valid_to_decoder  (inst_valid_to_decoder),
        .inst_to_decoder        (inst_to_decoder),
        .pc_to_decoder          (pc_to_decoder),
        .flush_from_commit      (flush_from_commit),
        .target_pc_from_commit  (target_pc_from_commit)
    );

    always #5 clk_in = ~clk_in;

    // Memory contents: 0x13 (NOP) in the low byte, address above it, so each word is distinct.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic flush, input logic [31:0] target, input logic stall);
        flush_from_commit     = flush;
        target_pc_from_commit = target;
        stall_from_decoder    = stall;
        tick();
        flush_from_commit     = 1'b0;
    endtask

    task automatic serve_miss(input logic [31:0] exp_addr, input int lat);
        for (int i = 0; i < 20 && !transmit_to_mem_ctrl; i++) tick();
        checkOutput("miss_req", 32'(transmit_to_mem_ctrl), 32'd1);
        checkOutput("miss_addr", inst_addr_to_mem_ctrl, exp_addr);
        for (int i = 1; i < lat; i++) tick();
        inst_rdy_from_mem_ctrl = 1'b1;
        inst_from_mem_ctrl     = word_at(exp_addr);
        #1;
        checkOutput("rdy_drop", 32'(transmit_to_mem_ctrl), 32'd0);
        tick();
        inst_rdy_from_mem_ctrl = 1'b0;
    endtask

    task automatic expect_issue(input logic [31:0] exp_pc);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (inst_valid_to_decoder) break;
        end
        checkOutput("issue_valid", 32'(inst_valid_to_decoder), 32'd1);
        checkOutput("issue_pc", pc_to_decoder, exp_pc);
        checkOutput("issue_inst", inst_to_decoder, word_at(exp_pc));
    endtask

    initial begin
        rst_n_in               = 1'b0;
        rdy_in                 = 1'b1;
        inst_rdy_from_mem_ctrl = 1'b0;
        inst_from_mem_ctrl     = 32'h0;
        stall_from_decoder     = 1'b0;
        flush_from_commit      = 1'b0;
        target_pc_from_commit  = 32'h0;
        #12;
        checkOutput("rst_valid", 32'(inst_valid_to_decoder), 32'd0);
        checkOutput("rst_inst", inst_to_decoder, 32'h0);
        checkOutput("rst_pc", pc_to_decoder, 32'h0);
        checkOutput("rst_transmit", 32'(transmit_to_mem_ctrl), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Cold start: four misses with 5-cycle memory, issued in order
        for (int k = 0; k < 4; k++) begin
            serve_miss(32'(4 * k), 5);
            expect_issue(32'(4 * k));
        end
        tick();
        checkOutput("valid_pulse", 32'(inst_valid_to_decoder), 32'd0);

        // Flush back to 0: four back-to-back hits with no memory traffic
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("flush_clears_valid", 32'(inst_valid_to_decoder), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("hit_valid", 32'(inst_valid_to_decoder), 32'd1);
            checkOutput("hit_pc", pc_to_decoder, 32'(4 * k));
            checkOutput("hit_no_transmit", 32'(transmit_to_mem_ctrl), 32'd0);
        end

        // Stall holds the output register for three cycles
        applyStimulus(1'b1, 32'h0, 1'b0);
        tick();
        checkOutput("pre_stall_pc", pc_to_decoder, 32'h0);
        stall_from_decoder = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("stall_valid", 32'(inst_valid_to_decoder), 32'd1);
            checkOutput("stall_pc", pc_to_decoder, 32'h0);
            checkOutput("stall_inst", inst_to_decoder, word_at(32'h0));
        end
        stall_from_decoder = 1'b0;
        tick();
        checkOutput("post_stall_pc", pc_to_decoder, 32'h4);
        tick();
        checkOutput("post_stall_pc2", pc_to_decoder, 32'h8);

        // Flush coincident with inst_rdy during a miss at 0x40
        applyStimulus(1'b1, 32'h40, 1'b0);
        tick();
        checkOutput("miss40_req", 32'(transmit_to_mem_ctrl), 32'd1);
        checkOutput("miss40_addr", inst_addr_to_mem_ctrl, 32'h40);
        tick();
        tick();
        inst_rdy_from_mem_ctrl = 1'b1;
        inst_from_mem_ctrl     = word_at(32'h40);
        flush_from_commit      = 1'b1;
        target_pc_from_commit  = 32'h100;
        #1;
        checkOutput("flush_transmit_drop", 32'(transmit_to_mem_ctrl), 32'd0);
        tick();
        inst_rdy_from_mem_ctrl = 1'b0;
        flush_from_commit      = 1'b0;
        tick();
        checkOutput("next_req_addr", inst_addr_to_mem_ctrl, 32'h100);
        serve_miss(32'h100, 3);
        expect_issue(32'h100);
        applyStimulus(1'b1, 32'h40, 1'b0);
        tick();
        checkOutput("line40_not_filled", 32'(transmit_to_mem_ctrl), 32'd1);
        serve_miss(32'h40, 2);
        expect_issue(32'h40);

        // Conflict: 0x400 shares index 0 with 0x0 and evicts it
        applyStimulus(1'b1, 32'h400, 1'b0);
        tick();
        checkOutput("conflict_miss", 32'(transmit_to_mem_ctrl), 32'd1);
        serve_miss(32'h400, 2);
        expect_issue(32'h400);
        applyStimulus(1'b1, 32'h0, 1'b0);
        tick();
        checkOutput("refetch0_miss", 32'(transmit_to_mem_ctrl), 32'd1);
        serve_miss(32'h0, 2);
        expect_issue(32'h0);
        tick();
        checkOutput("line4_still_hits", pc_to_decoder, 32'h4);
        checkOutput("line4_valid", 32'(inst_valid_to_decoder), 32'd1);

        // Asynchronous reset in the middle of a miss
        applyStimulus(1'b1, 32'h200, 1'b0);
        tick();
        checkOutput("miss200_req", 32'(transmit_to_mem_ctrl), 32'd1);
        tick();
        rst_n_in = 1'b0;
        #1;
        checkOutput("async_rst_transmit", 32'(transmit_to_mem_ctrl), 32'd0);
        checkOutput("async_rst_valid", 32'(inst_valid_to_decoder), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        checkOutput("addr_after_reset", inst_addr_to_mem_ctrl, 32'h0);
        checkOutput("miss_after_reset", 32'(transmit_to_mem_ctrl), 32'd1);

        // rdy_in low: a memory pulse is ignored and state, pc and outputs freeze
        rdy_in                 = 1'b0;
        inst_rdy_from_mem_ctrl = 1'b1;
        inst_from_mem_ctrl     = 32'hDEADBEEF;
        tick();
        inst_rdy_from_mem_ctrl = 1'b0;
        #1;
        checkOutput("frozen_miss_state", 32'(transmit_to_mem_ctrl), 32'd1);
        rdy_in = 1'b1;
        serve_miss(32'h0, 2);
        expect_issue(32'h0);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkOutput("frozen_valid", 32'(inst_valid_to_decoder), 32'd1);
        checkOutput("frozen_transmit", 32'(transmit_to_mem_ctrl), 32'd0);
        rdy_in = 1'b1;
        tick();
        checkOutput("pc_frozen", inst_addr_to_mem_ctrl, 32'h4);
        checkOutput("resume_miss", 32'(transmit_to_mem_ctrl), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
